// File: rtl/multiplexor_barrido.sv
// multiplexor_barrido: registered N-to-1 multiplexer with MANUAL and BARRIDO (scan) modes.
// Optional macro SALIDA_PARIDAD_EN adds the registered even-parity output Paridad.
module multiplexor_barrido #(
  parameter int ANCHO       = 3,
  parameter int CANALES     = 4,
  parameter int PERMANENCIA = 2,
  localparam int SEL_W      = ($clog2(CANALES) > 1) ? $clog2(CANALES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CANALES*ANCHO-1:0] Entradas,
  input  logic [SEL_W-1:0]         Selector,
  input  logic                     Modo,
  input  logic                     Habilitar,
  output logic [ANCHO-1:0]         Salida,
  output logic [SEL_W-1:0]         Canal,
  output logic                     Valido,
  output logic                     Fin_Barrido
`ifdef SALIDA_PARIDAD_EN
  ,
  output logic                     Paridad
`endif
);

  localparam int unsigned NSEL  = 2 ** SEL_W;
  localparam int          CNT_W = (PERMANENCIA > 1) ? $clog2(PERMANENCIA) : 1;

  typedef enum logic {MANUAL, BARRIDO} estado_t;

  estado_t          estado, estado_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ANCHO-1:0] salida_n;
  logic [SEL_W-1:0] canal_n;
  logic             valido_n;
  logic             fin_n;

  // Channel table padded to the full selector range; unused slots read as zero
  // and are flagged invalid so an out-of-range Selector is easy to detect.
  logic [ANCHO-1:0] ch [NSEL];
  logic [NSEL-1:0]  sel_ok;

  // Unpack the flat input bus into the padded channel table
  always_comb begin
    for (int unsigned i = 0; i < NSEL; i++) begin
      ch[i]     = '0;
      sel_ok[i] = 1'b0;
    end
    for (int unsigned i = 0; i < CANALES; i++) begin
      ch[i]     = Entradas[i*ANCHO +: ANCHO];
      sel_ok[i] = 1'b1;
    end
  end

  // Next-state, pointer/counter and output selection
  always_comb begin
    estado_n = estado;
    ptr_n    = ptr;
    cnt_n    = cnt;
    salida_n = Salida;
    canal_n  = Canal;
    valido_n = 1'b0;
    fin_n    = 1'b0;
    if (Habilitar) begin
      if (!Modo) begin
        // MANUAL output, also used on the BARRIDO -> MANUAL edge
        estado_n = MANUAL;
        if (sel_ok[Selector]) begin
          salida_n = ch[Selector];
          canal_n  = Selector;
          valido_n = 1'b1;
        end else begin
          salida_n = '0;
        end
      end else if (estado == MANUAL) begin
        estado_n = BARRIDO;
        ptr_n    = '0;
        cnt_n    = '0;
        salida_n = ch[0];
        canal_n  = '0;
        valido_n = 1'b1;
      end else begin
        if (cnt == CNT_W'(PERMANENCIA - 1)) begin
          cnt_n = '0;
          if (ptr == SEL_W'(CANALES - 1)) begin
            ptr_n = '0;
            fin_n = 1'b1;
          end else begin
            ptr_n = ptr + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
        salida_n = ch[ptr_n];
        canal_n  = ptr_n;
        valido_n = 1'b1;
      end
    end
  end

  // State and registered outputs, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= MANUAL;
      ptr         <= '0;
      cnt         <= '0;
      Salida      <= '0;
      Canal       <= '0;
      Valido      <= 1'b0;
      Fin_Barrido <= 1'b0;
    end else begin
      estado      <= estado_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      Salida      <= salida_n;
      Canal       <= canal_n;
      Valido      <= valido_n;
      Fin_Barrido <= fin_n;
    end
  end

`ifdef SALIDA_PARIDAD_EN
  // Even parity of the value loaded into Salida; salida_n holds when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Paridad <= 1'b0;
    else        Paridad <= ^salida_n;
  end
`endif

endmodule
